// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave shift engine driven by pre-detected SCLK edge pulses.
// Deserialises MOSI into words and serialises tx words onto MISO, MSB first.
module spi_slave_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclk_rise,
    input  logic                  sclk_fall,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  miso,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  load;

    // Next-state: frame control, rx shifting on rise, tx shift/reload on fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        load        = 1'b0;
        tx_ready    = 1'b0;
        tx_underrun = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!cs_n) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    load       = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_n) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = {rx_shift_q[DATA_WIDTH-2:0], mosi};
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A missing tx word is replaced by zeros and flagged.
        if (load) begin
            tx_shift_d  = tx_valid ? tx_data : '0;
            tx_ready    = tx_valid;
            tx_underrun = !tx_valid;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign busy     = (state_q == ACTIVE);
    assign miso     = busy & tx_shift_q[DATA_WIDTH-1];
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Scoreboard bench for spi_slave_shifter.
// Stimulus pushes expected words/events; a negedge monitor pops and compares.
module tb_spi_slave_shifter;

    logic       clock;
    logic       reset_n;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_n;
    logic       mosi;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic       miso;
    logic       busy;

    spi_slave_shifter #(.DATA_WIDTH(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_underrun(tx_underrun),
        .miso       (miso),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
    } word_t;

    localparam logic [1:0] EV_READY = 2'b10;
    localparam logic [1:0] EV_UNDER = 2'b01;

    word_t      exp_q[$];
    logic [1:0] ev_q[$];
    word_t      mw;
    logic [1:0] mev;
    logic [7:0] mon_sh;
    int         n_pass;
    int         n_total;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: got running required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Monitor: captures MISO at each counted rise, compares on output pulses.
    always @(negedge clock) begin
        if (!reset_n || !busy) mon_sh = '0;
        else if (sclk_rise && !cs_n) mon_sh = {mon_sh[6:0], miso};
        if (reset_n) begin
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rx_spurious", 32'(exp_q.size()), 1);
                end else begin
                    mw = exp_q.pop_front();
                    chk("rx_data", rx_data, mw.rx);
                    chk("miso_word", mon_sh, mw.tx);
                end
            end
            if (tx_ready || tx_underrun) begin
                if (ev_q.size() == 0) begin
                    chk("tx_ev_spurious", {tx_ready, tx_underrun}, 0);
                end else begin
                    mev = ev_q.pop_front();
                    chk("tx_event", {tx_ready, tx_underrun}, mev);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic edge_p(input logic r, input logic f, input logic last);
        sclk_rise = r;
        sclk_fall = f;
        tick();
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
        if (r) chk("rx_valid_lat", rx_valid, last);
        tick();
    endtask

    task automatic send_bit(input logic b, input logic last);
        mosi = b;
        edge_p(1'b1, 1'b0, last);
        edge_p(1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w, input int combo);
        for (int i = 7; i >= 0; i--) begin
            if (7 - i == combo) begin
                mosi = w[i];
                edge_p(1'b1, 1'b1, i == 0);
                edge_p(1'b0, 1'b1, 1'b0);
            end else begin
                send_bit(w[i], i == 0);
            end
        end
    endtask

    task automatic frame_start(input logic [7:0] t, input logic v);
        tx_data  = t;
        tx_valid = v;
        ev_q.push_back(v ? EV_READY : EV_UNDER);
        cs_n = 1'b0;
        tick();
        chk("busy_on", busy, 1);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset_n   = 1'b0;
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
        cs_n      = 1'b1;
        mosi      = 1'b0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        #12;
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miso", miso, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_tx_underrun", tx_underrun, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single word: tx 0x3C, rx 0xA5.
        frame_start(8'h3C, 1'b1);
        tx_valid = 1'b0;
        exp_q.push_back('{rx: 8'hA5, tx: 8'h3C});
        ev_q.push_back(EV_UNDER);
        send_word(8'hA5, -1);
        cs_high();

        // Three words with underrun on the second boundary.
        frame_start(8'h11, 1'b1);
        tx_data = 8'h22;
        exp_q.push_back('{rx: 8'h01, tx: 8'h11});
        exp_q.push_back('{rx: 8'h80, tx: 8'h22});
        exp_q.push_back('{rx: 8'hFF, tx: 8'h00});
        ev_q.push_back(EV_READY);
        ev_q.push_back(EV_UNDER);
        ev_q.push_back(EV_UNDER);
        send_word(8'h01, -1);
        tx_valid = 1'b0;
        send_word(8'h80, -1);
        send_word(8'hFF, -1);
        cs_high();

        // Reset in the middle of a word.
        frame_start(8'h96, 1'b1);
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        reset_n = 1'b0;
        cs_n    = 1'b1;
        #2;
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_tx_ready", tx_ready, 0);
        tick();
        reset_n = 1'b1;
        tick();
        frame_start(8'h5C, 1'b1);
        tx_valid = 1'b0;
        exp_q.push_back('{rx: 8'h4B, tx: 8'h5C});
        ev_q.push_back(EV_UNDER);
        send_word(8'h4B, -1);
        cs_high();

        // Partial word aborted by CS, then a full frame.
        frame_start(8'hE7, 1'b1);
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        cs_n = 1'b1;
        chk("busy_before_drop", busy, 1);
        tick();
        chk("busy_after_drop", busy, 0);
        chk("miso_after_drop", miso, 0);
        tick();
        frame_start(8'h0F, 1'b1);
        tx_valid = 1'b0;
        exp_q.push_back('{rx: 8'h5A, tx: 8'h0F});
        ev_q.push_back(EV_UNDER);
        send_word(8'h5A, -1);
        cs_high();

        // Edges while deselected, rise coincident with CS assertion.
        mosi = 1'b1;
        edge_p(1'b1, 1'b0, 1'b0);
        edge_p(1'b0, 1'b1, 1'b0);
        edge_p(1'b1, 1'b1, 1'b0);
        chk("idle_busy", busy, 0);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        ev_q.push_back(EV_READY);
        cs_n      = 1'b0;
        sclk_rise = 1'b1;
        tick();
        sclk_rise = 1'b0;
        chk("coinc_busy", busy, 1);
        tick();
        tx_valid = 1'b0;
        exp_q.push_back('{rx: 8'h33, tx: 8'hC3});
        ev_q.push_back(EV_UNDER);
        send_word(8'h33, -1);
        cs_high();

        // Rise and fall together mid-word: fall must be dropped.
        frame_start(8'hA9, 1'b1);
        tx_valid = 1'b0;
        exp_q.push_back('{rx: 8'hC6, tx: 8'hA9});
        ev_q.push_back(EV_UNDER);
        send_word(8'hC6, 3);
        cs_high();

        repeat (4) tick();
        chk("rx_queue_drained", 32'(exp_q.size()), 0);
        chk("ev_queue_drained", 32'(ev_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_slave_shifter.md
Name: spi_slave_shifter

Overview:
SPI mode-0 slave shift engine that consumes the one-cycle SCLK edge pulses produced by the SPI driver's posedge/negedge detectors. It deserialises MOSI into parallel words and serialises outgoing words onto MISO, MSB first. It sits between the edge-detect front end and the command/framebuffer decoder in the SPI driver. All inputs are already synchronised to `clock`. `mosi` and `cs_n` must pass through the same two-stage delay as SCLK upstream, so they stay phase-aligned with the edge pulses.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (minimum 2).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sclk_rise  in  1  one-cycle pulse: SCLK rising edge detected.
- sclk_fall  in  1  one-cycle pulse: SCLK falling edge detected.
- cs_n  in  1  synchronised chip select, active low.
- mosi  in  1  synchronised MOSI, aligned to sclk_rise.
- rx_data  out  DATA_WIDTH  last completed received word.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- tx_data  in  DATA_WIDTH  next word to transmit.
- tx_valid  in  1  tx_data holds a word to send.
- tx_ready  out  1  one-cycle pulse: tx_data consumed this cycle.
- tx_underrun  out  1  one-cycle pulse: word load with tx_valid low; zeros sent.
- miso  out  1  serial out (top level tri-states it when cs_n is high).
- busy  out  1  high while the transaction state is ACTIVE.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0, state IDLE, bit_cnt 0, rx/tx shift registers 0.
- States: IDLE and ACTIVE.
- IDLE -> ACTIVE: cycle where cs_n = 0.
  - Clears bit_cnt and rx shift register.
  - Loads tx shift register with tx_data if tx_valid (pulse tx_ready), else loads 0 (pulse tx_underrun).
  - Edge pulses arriving in that same cycle are ignored.
- ACTIVE -> IDLE: any cycle with cs_n = 1.
  - Partial word discarded; no rx_valid.
  - bit_cnt cleared; miso returns to 0 the next cycle.
  - Edge pulses in that cycle are ignored; deassertion wins.
- ACTIVE, sclk_rise:
  - rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi}; bit_cnt increments.
  - If bit_cnt was DATA_WIDTH-1: the completed word is written to rx_data and rx_valid pulses on the following cycle (1-cycle latency from the final sclk_rise), and bit_cnt wraps to 0.
- ACTIVE, sclk_fall:
  - bit_cnt != 0: tx shift register shifts left by one, zero-filled.
  - bit_cnt == 0 (word boundary after a full word): load the next word with the same tx_valid/tx_ready/tx_underrun rule as CS assertion.
- sclk_rise and sclk_fall in the same cycle: rise processed, fall ignored.
- Any edge pulse while IDLE: ignored.
- miso = MSB of tx shift register while ACTIVE; 0 while IDLE.
- No backpressure on rx: downstream must accept rx_valid every time it pulses. rx_data holds its value until the next completed word.
- tx_ready and tx_underrun are mutually exclusive, each at most one cycle per word.
- busy mirrors the state (1 in ACTIVE).
- Back-to-back words within one CS frame are unlimited; bit_cnt wraps modulo DATA_WIDTH.

Test Plan:
1. Reset mid-transaction (reset_n low for 1 cycle after 5 bits) -> all outputs 0, IDLE; next frame decodes correctly from bit 0.
2. Single-word frame, DATA_WIDTH=8, tx_valid=1, tx_data=0x3C, MOSI=0xA5 -> tx_ready pulse at CS assertion; MISO bits 0,0,1,1,1,1,0,0; rx_data=0xA5 with rx_valid one cycle after the 8th sclk_rise.
3. Three-word frame, MOSI 0x01,0x80,0xFF; tx_data 0x11,0x22 then tx_valid low -> rx_valid ×3 with correct data; tx_ready at CS assertion and first word boundary; tx_underrun at second boundary; third MISO word 0x00.
4. CS deasserted after 5 bits, then a new frame sending 0x5A -> no rx_valid for the partial word; new frame yields rx_data=0x5A; busy drops the cycle after cs_n rises.
5. Edge pulses while cs_n=1, plus sclk_rise coincident with the cs_n falling cycle -> no state change; the first counted bit is the next sclk_rise.
6. sclk_rise and sclk_fall asserted in the same cycle mid-word -> one bit shifted into rx; tx shift register unchanged.
